// File: rtl/toast_dmem_responder.sv
// Toast RV32I data-memory slave: word-organised RAM plus a small MMIO window
// (tohost status, GPIO, 64-bit cycle counter with latched high half).
module toast_dmem_responder #(
  parameter int          DMEM_DEPTH_WORDS  = 1024,
  parameter int          GPIO_WIDTH        = 8,
  parameter logic [63:0] CYCLE_RESET_VALUE = 64'd0
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic [31:0]           DMEM_addr_i,
  input  logic [3:0]            DMEM_wr_byte_en_i,
  input  logic [31:0]           DMEM_wr_data_i,
  input  logic                  DMEM_rst_i,
  output logic [31:0]           DMEM_rd_data_o,
  output logic [GPIO_WIDTH-1:0] gpio_o,
  output logic                  done_o,
  output logic                  pass_o
);
  // No handshake: every cycle is one access. The address is sampled at each
  // rising edge, write lanes commit at that edge, and the read word (pre-write
  // value) is presented on DMEM_rd_data_o until the following edge.

  localparam int AW = $clog2(DMEM_DEPTH_WORDS);

  localparam logic [2:0] REG_TOHOST   = 3'd0;
  localparam logic [2:0] REG_GPIO     = 3'd1;
  localparam logic [2:0] REG_CYCLE_LO = 3'd2;
  localparam logic [2:0] REG_CYCLE_HI = 3'd3;

  logic [31:0]           mem [DMEM_DEPTH_WORDS];
  logic [AW-1:0]         word_idx;
  logic                  is_mmio;
  logic [2:0]            reg_sel;
  logic [31:0]           be_mask;
  logic                  ram_we;
  logic                  mmio_we;
  logic [31:0]           rd_data_q;
  logic [31:0]           rd_data_d;
  logic [31:0]           tohost_q;
  logic [31:0]           tohost_d;
  logic [31:0]           shadow_q;
  logic [31:0]           gpio_ext;
  logic [GPIO_WIDTH-1:0] gpio_q;
  logic [GPIO_WIDTH-1:0] gpio_d;
  logic [63:0]           cycle_q;
  logic                  done_q;
  logic                  unused_addr;

  assign word_idx = DMEM_addr_i[AW+1:2];
  assign is_mmio  = DMEM_addr_i[31];
  assign reg_sel  = DMEM_addr_i[4:2];
  assign be_mask  = {{8{DMEM_wr_byte_en_i[3]}}, {8{DMEM_wr_byte_en_i[2]}},
                     {8{DMEM_wr_byte_en_i[1]}}, {8{DMEM_wr_byte_en_i[0]}}};
  // RAM writes go through even in reset so the array needs no reset path.
  assign ram_we   = !is_mmio && (DMEM_wr_byte_en_i != 4'h0);
  assign mmio_we  = is_mmio && (DMEM_wr_byte_en_i != 4'h0) && resetn_i;

  // Alias bits and the byte offset are deliberately ignored by the decode.
  assign unused_addr = ^DMEM_addr_i;

  always_ff @(posedge clk_i) begin
    if (ram_we && DMEM_wr_byte_en_i[0]) mem[word_idx][7:0]   <= DMEM_wr_data_i[7:0];
    if (ram_we && DMEM_wr_byte_en_i[1]) mem[word_idx][15:8]  <= DMEM_wr_data_i[15:8];
    if (ram_we && DMEM_wr_byte_en_i[2]) mem[word_idx][23:16] <= DMEM_wr_data_i[23:16];
    if (ram_we && DMEM_wr_byte_en_i[3]) mem[word_idx][31:24] <= DMEM_wr_data_i[31:24];
  end

  always_comb begin
    gpio_ext = '0;
    gpio_ext[GPIO_WIDTH-1:0] = gpio_q;
  end

  always_comb begin
    tohost_d = tohost_q;
    gpio_d   = gpio_q;
    if (mmio_we && (reg_sel == REG_TOHOST) && !done_q) begin
      tohost_d = (tohost_q & ~be_mask) | (DMEM_wr_data_i & be_mask);
    end
    if (mmio_we && (reg_sel == REG_GPIO)) begin
      gpio_d = (gpio_q & ~be_mask[GPIO_WIDTH-1:0]) |
               (DMEM_wr_data_i[GPIO_WIDTH-1:0] & be_mask[GPIO_WIDTH-1:0]);
    end
  end

  always_comb begin
    rd_data_d = '0;
    if (!is_mmio) begin
      rd_data_d = mem[word_idx];
    end else begin
      case (reg_sel)
        REG_TOHOST:   rd_data_d = tohost_q;
        REG_GPIO:     rd_data_d = gpio_ext;
        REG_CYCLE_LO: rd_data_d = cycle_q[31:0];
        REG_CYCLE_HI: rd_data_d = shadow_q;
        default:      rd_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      rd_data_q <= '0;
      tohost_q  <= '0;
      gpio_q    <= '0;
      shadow_q  <= '0;
      done_q    <= 1'b0;
      cycle_q   <= CYCLE_RESET_VALUE;
    end else begin
      rd_data_q <= DMEM_rst_i ? 32'd0 : rd_data_d;
      tohost_q  <= tohost_d;
      gpio_q    <= gpio_d;
      done_q    <= done_q | (tohost_d != 32'd0);
      // High half is latched from the same counter value the low read returns.
      if (is_mmio && (reg_sel == REG_CYCLE_LO)) shadow_q <= cycle_q[63:32];
      cycle_q   <= cycle_q + 64'd1;
    end
  end

  assign DMEM_rd_data_o = rd_data_q;
  assign gpio_o         = gpio_q;
  assign done_o         = done_q;
  assign pass_o         = done_q && (tohost_q == 32'd1);

endmodule

// File: tb/tb_toast_dmem_responder.sv
// Bench for toast_dmem_responder: directed vector table, counter/reset sequences,
// and random traffic checked against a byte-level reference model.
module tb_toast_dmem_responder;
  localparam int          DEPTH  = 1024;
  localparam int          GW     = 8;
  localparam logic [63:0] W_INIT = 64'hFFFF_FFFF_FFFF_FFF0;
  localparam logic [31:0] A_TOHOST = 32'h8000_0000;
  localparam logic [31:0] A_GPIO   = 32'h8000_0004;
  localparam logic [31:0] A_LO     = 32'h8000_0008;
  localparam logic [31:0] A_HI     = 32'h8000_000C;

  // ---------------- clock / reset / DUTs ----------------
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          resetn_i;
  logic [31:0]   addr;
  logic [3:0]    be;
  logic [31:0]   wd;
  logic          drst;
  logic [31:0]   rd;
  logic [GW-1:0] gpio;
  logic          done;
  logic          pass;

  logic [31:0]   w_addr;
  logic [31:0]   w_rd;
  logic [GW-1:0] w_gpio;
  logic          w_done;
  logic          w_pass;

  toast_dmem_responder #(.DMEM_DEPTH_WORDS(DEPTH), .GPIO_WIDTH(GW)) dut (
    .clk_i(clk_i), .resetn_i(resetn_i), .DMEM_addr_i(addr),
    .DMEM_wr_byte_en_i(be), .DMEM_wr_data_i(wd), .DMEM_rst_i(drst),
    .DMEM_rd_data_o(rd), .gpio_o(gpio), .done_o(done), .pass_o(pass)
  );

  // Second instance preloaded near the top of the counter range for wrap checks.
  toast_dmem_responder #(.DMEM_DEPTH_WORDS(DEPTH), .GPIO_WIDTH(GW),
                         .CYCLE_RESET_VALUE(W_INIT)) dut_w (
    .clk_i(clk_i), .resetn_i(resetn_i), .DMEM_addr_i(w_addr),
    .DMEM_wr_byte_en_i(4'h0), .DMEM_wr_data_i(32'h0), .DMEM_rst_i(1'b0),
    .DMEM_rd_data_o(w_rd), .gpio_o(w_gpio), .done_o(w_done), .pass_o(w_pass)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  m_ram [4*DEPTH];
  bit          m_known [DEPTH];
  logic [31:0] m_tohost;
  logic [31:0] m_gpio;
  logic [31:0] m_shadow;
  logic        m_done;
  logic [63:0] m_cnt;
  logic [63:0] w_cnt;
  logic [31:0] w_shadow;
  logic [31:0] w_exp;

  function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] d,
                                             input logic [3:0] b);
    logic [31:0] m;
    m = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    return (old & ~m) | (d & m);
  endfunction

  task automatic model_step(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d,
                            input logic r, input logic rn, output bit known);
    int          base;
    logic [31:0] val;
    base  = int'(a & 32'(4*DEPTH-1));
    base  = base & ~3;
    known = 1'b1;
    val   = 32'd0;
    if (!a[31]) begin
      val   = {m_ram[base+3], m_ram[base+2], m_ram[base+1], m_ram[base]};
      known = m_known[base/4];
      for (int k = 0; k < 4; k++)
        if (b[k[1:0]]) m_ram[base+k] = 8'(d >> (8*k));
      if (b == 4'hF) m_known[base/4] = 1'b1;
    end else if (rn) begin
      case (a[4:2])
        3'd0: val = m_tohost;
        3'd1: val = m_gpio;
        3'd2: val = m_cnt[31:0];
        3'd3: val = m_shadow;
        default: val = 32'd0;
      endcase
      if (a[4:2] == 3'd2) m_shadow = m_cnt[63:32];
    end
    if (!rn || r) begin
      val   = 32'd0;
      known = 1'b1;
    end
    if (!rn) begin
      m_tohost = 0; m_gpio = 0; m_shadow = 0; m_done = 0; m_cnt = 64'd0;
    end else begin
      if (a[31] && a[4:2] == 3'd0 && !m_done) m_tohost = lane_merge(m_tohost, d, b);
      if (a[31] && a[4:2] == 3'd1) m_gpio = lane_merge(m_gpio, d, b) & 32'hFF;
      if (m_tohost != 0) m_done = 1'b1;
      m_cnt = m_cnt + 64'd1;
    end
    exp_q.push_back(val);
  endtask

  task automatic w_step(input logic rn);
    if (!rn) begin
      w_exp = 0; w_cnt = W_INIT; w_shadow = 0;
    end else begin
      case (w_addr[4:2])
        3'd2: w_exp = w_cnt[31:0];
        3'd3: w_exp = w_shadow;
        default: w_exp = 32'd0;
      endcase
      if (w_addr[4:2] == 3'd2) w_shadow = w_cnt[63:32];
      w_cnt = w_cnt + 64'd1;
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d,
                       input logic r, input logic rn);
    bit          known;
    logic [31:0] e;
    addr = a; be = b; wd = d; drst = r; resetn_i = rn;
    @(posedge clk_i);
    model_step(a, b, d, r, rn, known);
    w_step(rn);
    #1;
    e = exp_q.pop_front();
    if (known) check("rd_data", rd, e);
    check("gpio", {24'd0, gpio}, m_gpio);
    check("done", {31'd0, done}, {31'd0, m_done});
    check("pass", {31'd0, pass}, {31'd0, (m_done && m_tohost == 32'd1)});
    if (w_addr[31]) check("w_rd_data", w_rd, w_exp);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        rst;
    logic [31:0] exp_rd;
    logic [7:0]  exp_gpio;
    logic        exp_done;
    logic        exp_pass;
  } vec_t;

  vec_t vecs[$];

  initial begin
    addr = 0; be = 0; wd = 0; drst = 0; resetn_i = 0; w_addr = A_TOHOST;
    for (int k = 0; k < DEPTH; k++) m_known[k] = 1'b0;

    vecs.push_back(vec_t'{32'h10,   4'hF, 32'hDEADBEEF, 1'b0, 32'h0,        8'h00, 1'b0, 1'b0});
    vecs.push_back(vec_t'{32'h10,   4'h0, 32'h0,        1'b0, 32'hDEADBEEF, 8'h00, 1'b0, 1'b0});
    vecs.push_back(vec_t'{32'h20,   4'hF, 32'h11223344, 1'b0, 32'h0,        8'h00, 1'b0, 1'b0});
    vecs.push_back(vec_t'{32'h20,   4'h5, 32'hAABBCCDD, 1'b0, 32'h11223344, 8'h00, 1'b0, 1'b0});
    vecs.push_back(vec_t'{32'h20,   4'h0, 32'h0,        1'b0, 32'h11BB33DD, 8'h00, 1'b0, 1'b0});
    vecs.push_back(vec_t'{32'h20 + 32'(4*DEPTH), 4'h0, 32'h0, 1'b0, 32'h11BB33DD, 8'h00, 1'b0, 1'b0});
    vecs.push_back(vec_t'{32'h4000_1022, 4'h0, 32'h0,   1'b0, 32'h11BB33DD, 8'h00, 1'b0, 1'b0});
    vecs.push_back(vec_t'{32'h40,   4'hF, 32'h1,        1'b0, 32'h0,        8'h00, 1'b0, 1'b0});
    vecs.push_back(vec_t'{32'h40,   4'hF, 32'h2,        1'b0, 32'h1,        8'h00, 1'b0, 1'b0});
    vecs.push_back(vec_t'{32'h40,   4'h0, 32'h0,        1'b0, 32'h2,        8'h00, 1'b0, 1'b0});
    vecs.push_back(vec_t'{32'h44,   4'hF, 32'h55,       1'b1, 32'h0,        8'h00, 1'b0, 1'b0});
    vecs.push_back(vec_t'{32'h44,   4'h0, 32'h0,        1'b0, 32'h55,       8'h00, 1'b0, 1'b0});
    vecs.push_back(vec_t'{32'h40,   4'h0, 32'h0,        1'b1, 32'h0,        8'h00, 1'b0, 1'b0});
    vecs.push_back(vec_t'{A_GPIO,   4'hF, 32'h000000A5, 1'b0, 32'h0,        8'hA5, 1'b0, 1'b0});
    vecs.push_back(vec_t'{A_GPIO,   4'h0, 32'h0,        1'b0, 32'hA5,       8'hA5, 1'b0, 1'b0});
    vecs.push_back(vec_t'{32'h8000_0014, 4'hF, 32'hFFFFFFFF, 1'b0, 32'h0,   8'hA5, 1'b0, 1'b0});
    vecs.push_back(vec_t'{32'h8000_0014, 4'h0, 32'h0,   1'b0, 32'h0,        8'hA5, 1'b0, 1'b0});
    vecs.push_back(vec_t'{A_GPIO,   4'h2, 32'h00003C00, 1'b0, 32'hA5,       8'hA5, 1'b0, 1'b0});
    vecs.push_back(vec_t'{32'h8000_0007, 4'h1, 32'h5A, 1'b0, 32'hA5,        8'h5A, 1'b0, 1'b0});
    vecs.push_back(vec_t'{32'h8FFF_FFE4, 4'h0, 32'h0,   1'b0, 32'h5A,       8'h5A, 1'b0, 1'b0});
    vecs.push_back(vec_t'{A_TOHOST, 4'hF, 32'h1,        1'b0, 32'h0,        8'h5A, 1'b1, 1'b1});
    vecs.push_back(vec_t'{A_TOHOST, 4'hF, 32'h3,        1'b0, 32'h1,        8'h5A, 1'b1, 1'b1});
    vecs.push_back(vec_t'{A_TOHOST, 4'h0, 32'h0,        1'b0, 32'h1,        8'h5A, 1'b1, 1'b1});

    // Reset state.
    repeat (2) cycle(32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    check("reset_rd", rd, 32'h0);
    check("reset_gpio", {24'd0, gpio}, 32'h0);
    check("reset_done", {31'd0, done}, 32'h0);
    check("reset_pass", {31'd0, pass}, 32'h0);

    // Counter: low read returns pre-increment value, high read returns latched half.
    w_addr = A_LO; cycle(A_LO, 4'h0, 32'h0, 1'b0, 1'b1);
    check("cyc_lo_first", rd, 32'h0);
    check("w_lo_first", w_rd, 32'hFFFF_FFF0);
    w_addr = A_HI; cycle(A_LO, 4'h0, 32'h0, 1'b0, 1'b1);
    check("cyc_lo_second", rd, 32'h1);
    check("w_hi_first", w_rd, 32'hFFFF_FFFF);
    w_addr = A_TOHOST; cycle(A_HI, 4'h0, 32'h0, 1'b0, 1'b1);
    check("cyc_hi_first", rd, 32'h0);
    repeat (12) cycle(A_TOHOST, 4'h0, 32'h0, 1'b0, 1'b1);
    w_addr = A_LO; cycle(A_TOHOST, 4'h0, 32'h0, 1'b0, 1'b1);
    check("w_lo_allones", w_rd, 32'hFFFF_FFFF);
    w_addr = A_HI; cycle(A_TOHOST, 4'h0, 32'h0, 1'b0, 1'b1);
    check("w_hi_shadow_not_live", w_rd, 32'hFFFF_FFFF);
    w_addr = A_LO; cycle(A_TOHOST, 4'h0, 32'h0, 1'b0, 1'b1);
    check("w_lo_wrapped", w_rd, 32'h1);
    w_addr = A_HI; cycle(A_TOHOST, 4'h0, 32'h0, 1'b0, 1'b1);
    check("w_hi_wrapped", w_rd, 32'h0);
    w_addr = A_TOHOST;
    check("w_idle_outputs", {22'd0, w_gpio, w_done, w_pass}, 32'h0);

    // Fill RAM with zeros so every word is known to the model.
    for (int k = 0; k < DEPTH; k++) cycle(32'(k*4), 4'hF, 32'h0, 1'b0, 1'b1);

    foreach (vecs[i]) begin
      cycle(vecs[i].addr, vecs[i].be, vecs[i].wd, vecs[i].rst, 1'b1);
      check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_gpio", i), {24'd0, gpio}, {24'd0, vecs[i].exp_gpio});
      check($sformatf("vec%0d_done", i), {31'd0, done}, {31'd0, vecs[i].exp_done});
      check($sformatf("vec%0d_pass", i), {31'd0, pass}, {31'd0, vecs[i].exp_pass});
    end

    // Reset discards MMIO writes but still performs RAM writes.
    cycle(A_TOHOST, 4'hF, 32'h3, 1'b0, 1'b0);
    check("rst_tohost_done", {31'd0, done}, 32'h0);
    check("rst_gpio_cleared", {24'd0, gpio}, 32'h0);
    cycle(32'h80, 4'hF, 32'h1234, 1'b0, 1'b0);
    cycle(32'h80, 4'h0, 32'h0, 1'b0, 1'b1);
    check("rst_ram_write_kept", rd, 32'h1234);
    cycle(A_TOHOST, 4'hF, 32'h3, 1'b0, 1'b1);
    check("tohost3_done", {31'd0, done}, 32'h1);
    check("tohost3_pass", {31'd0, pass}, 32'h0);
    cycle(A_TOHOST, 4'h0, 32'h0, 1'b0, 1'b1);
    check("tohost3_read", rd, 32'h3);
    cycle(A_TOHOST, 4'h0, 32'h0, 1'b0, 1'b0);
    check("reset_clears_done", {31'd0, done}, 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  b;
      logic        r;
      logic        rn;
      a = $urandom;
      if ($urandom_range(0, 2) == 0) begin
        a[31] = 1'b1;
      end else begin
        a[31] = 1'b0;
        if ($urandom_range(0, 1) == 1) a[11:2] = 10'($urandom_range(0, 15));
      end
      b  = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      d  = $urandom;
      if (a[31] && a[4:2] == 3'd0 && $urandom_range(0, 1) == 1) d = 32'd1;
      r  = ($urandom_range(0, 15) == 0);
      rn = ($urandom_range(0, 255) != 0);
      cycle(a, b, d, r, rn);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/toast_dmem_responder.md
# toast_dmem_responder

Data-memory responder for the Toast RV32I core: the slave end of the core's DMEM interface (byte-enable write, registered read, read-data reset). Provides word-organised on-chip RAM plus a small MMIO window with a test-status register (tohost), a GPIO output register and a free-running 64-bit cycle counter. It sits beside the core at SoC/testbench top level, with its ports wired one-to-one to the core's DMEM ports.

## Interface
Parameters:
- DMEM_DEPTH_WORDS, 1024: RAM depth in 32-bit words; power of two. AW = log2(DMEM_DEPTH_WORDS).
- GPIO_WIDTH, 8: width of gpio_o; 1..32.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- resetn_i  in  1  reset; synchronous and active-low.
- DMEM_addr_i  in  32  byte address, sampled every cycle.
- DMEM_wr_byte_en_i  in  4  per-lane write enable; bit n writes DMEM_wr_data_i[8n+7:8n]. All zero means read only.
- DMEM_wr_data_i  in  32  write data, lane-aligned by the core.
- DMEM_rst_i  in  1  synchronous clear of the read-data register only.
- DMEM_rd_data_o  out  32  registered read data.
- gpio_o  out  GPIO_WIDTH  GPIO register.
- done_o  out  1  sticky; set once tohost holds a nonzero value.
- pass_o  out  1  high when done_o is high and tohost == 1.

## Operation
- Decode uses DMEM_addr_i[31]:
  - 0: RAM region. Word index = DMEM_addr_i[AW+1:2]. Bits [30:AW+2] are ignored, so addresses alias with wrap-around.
  - 1: MMIO region. Register select = DMEM_addr_i[4:2]. Bits [30:5] are ignored.
- DMEM_addr_i[1:0] is ignored everywhere; lane selection comes only from DMEM_wr_byte_en_i.
- RAM write: each enabled byte lane is written at the edge. Lanes not enabled keep their value.
- MMIO map:
  - 0 TOHOST (RW): byte-enable merge into a 32-bit register. Writes are ignored once done_o is 1.
  - 1 GPIO (RW): byte-enable merge into the low GPIO_WIDTH bits. Reads return the value zero-extended.
  - 2 CYCLE_LO (RO): counter[31:0]. Reading it also copies counter[63:32] into a 32-bit shadow register.
  - 3 CYCLE_HI (RO): returns the shadow register, not the live counter.
  - 4..7: read 0; writes ignored. Writes to 2 and 3 are also ignored.
- Cycle counter: 64-bit, +1 every cycle, wraps from 2^64-1 to 0. Not affected by DMEM_rst_i.
- Read-data register: loaded every cycle with the word at the sampled address. There is no read enable.
- Read-during-write to the same location: read-first. DMEM_rd_data_o shows the pre-write value; the new value is visible on the next access.
- DMEM_rst_i = 1: read-data register loads 0 that cycle, taking priority over the load. Writes still take effect.
- done_o is set at the edge after which TOHOST != 0. It stays set until resetn_i.
- Reset (resetn_i = 0 at an edge):
  - DMEM_rd_data_o, gpio_o, TOHOST, the shadow register, counter, done_o and pass_o all go to 0.
  - RAM contents are not cleared.
  - A write presented in the reset cycle is discarded for MMIO. For RAM the write is performed, so the RAM needs no reset path.
  - Reset in the middle of a sequence takes effect at that edge; no pending state survives.

## Timing
- Read latency is 1 cycle: address sampled at edge k, data on DMEM_rd_data_o after edge k, held until edge k+1.
- Write latency is 0 cycles of visibility: a write at edge k is readable by an address sampled at edge k+1, with data out after k+1.
- CYCLE_LO sampled at edge k returns the counter value before that edge's increment. The shadow register captures the high half from the same counter value.
- gpio_o and done_o change at the write edge; pass_o is combinational from done_o and TOHOST.
- Throughput: one access per cycle, no stalls, no handshake.

## Test plan
- Reset, then read word 0x0 → DMEM_rd_data_o = 0 for the first cycle. Write 0xDEADBEEF with byte_en=4'hF to 0x10, then read 0x10 → 0xDEADBEEF one cycle after the address.
- Byte-lane merge: word 0x20 = 0x11223344, write 0xAABBCCDD with byte_en=4'b0101 → read returns 0x11BB33DD. Address 0x20 + 4*DMEM_DEPTH_WORDS aliases and returns the same value.
- Read-during-write: word 0x40 = 0x1, write 0x2 to 0x40 while reading it → DMEM_rd_data_o = 0x1 that cycle, 0x2 on the following read. Assert DMEM_rst_i during a read → DMEM_rd_data_o = 0 for that cycle, and the write still lands.
- MMIO GPIO: write 0x0000_00A5 to 0x8000_0004 → gpio_o = 8'hA5 after the edge, and a read returns 0x000000A5. A write to 0x8000_0014 has no effect and reads 0.
- Cycle counter: force the counter to 0x0000_0001_FFFF_FFFF, read CYCLE_LO, then read CYCLE_HI → the high read returns 1, not the incremented 2. Check wrap from all-ones to 0.
- TOHOST write 1 → done_o = 1 and pass_o = 1. Then write 3 → no change. After reset, write 3 → done_o = 1 and pass_o = 0. Drop resetn_i → done_o = 0.
